// File: rtl/id_exe_reg_pkg.sv
// Shared constants and types for the ID/EXE pipeline boundary.
// Holds the ALU command encoding and the decoded control bundle.
package id_exe_reg_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_ID_W = 4;
   localparam int CMD_W    = 4;
   localparam int CNT_W    = 16;

   typedef enum logic [CMD_W-1:0] {
      CMD_MOV = 4'd0,
      CMD_MVN = 4'd1,
      CMD_ADD = 4'd2,
      CMD_ADC = 4'd3,
      CMD_SUB = 4'd4,
      CMD_SBC = 4'd5,
      CMD_AND = 4'd6,
      CMD_ORR = 4'd7,
      CMD_EOR = 4'd8,
      CMD_CMP = 4'd9,
      CMD_TST = 4'd10,
      CMD_LDR = 4'd11,
      CMD_STR = 4'd12
   } exe_cmd_e;

   typedef struct packed {
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
      logic b;
      logic s;
   } ctrl_t;

endpackage

// File: rtl/id_exe_reg_sat_counter.sv
// Width-parameterised saturating up-counter with enable.
// Clears asynchronously; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, branch-flush bubbles
// and a saturating bubble counter for performance debug.
module id_exe_reg
   import id_exe_reg_pkg::*;
#(
   parameter int DATA_W   = id_exe_reg_pkg::DATA_W,
   parameter int REG_ID_W = id_exe_reg_pkg::REG_ID_W,
   parameter int CMD_W    = id_exe_reg_pkg::CMD_W,
   parameter int CNT_W    = id_exe_reg_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                freeze,
   input  logic                flush,
   input  logic                valid_in,
   input  logic                wb_en_in,
   input  logic                mem_r_en_in,
   input  logic                mem_w_en_in,
   input  logic                b_in,
   input  logic                s_in,
   input  logic [CMD_W-1:0]    exe_cmd_in,
   input  logic [DATA_W-1:0]   pc_in,
   input  logic [DATA_W-1:0]   val_rn_in,
   input  logic [DATA_W-1:0]   val_rm_in,
   input  logic                imm_in,
   input  logic [11:0]         shift_operand_in,
   input  logic [23:0]         signed_imm_24_in,
   input  logic [REG_ID_W-1:0] dest_in,
   input  logic [REG_ID_W-1:0] src1_in,
   input  logic [REG_ID_W-1:0] src2_in,
   input  logic [3:0]          status_in,
   output logic                valid_out,
   output logic                wb_en_out,
   output logic                mem_r_en_out,
   output logic                mem_w_en_out,
   output logic                b_out,
   output logic                s_out,
   output logic [CMD_W-1:0]    exe_cmd_out,
   output logic [DATA_W-1:0]   pc_out,
   output logic [DATA_W-1:0]   val_rn_out,
   output logic [DATA_W-1:0]   val_rm_out,
   output logic                imm_out,
   output logic [11:0]         shift_operand_out,
   output logic [23:0]         signed_imm_24_out,
   output logic [REG_ID_W-1:0] dest_out,
   output logic [REG_ID_W-1:0] src1_out,
   output logic [REG_ID_W-1:0] src2_out,
   output logic [3:0]          status_out,
   output logic [CNT_W-1:0]    bubble_cnt
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;
   logic  bubble;

   // Dead slots carry no control so forwarding/hazard never match them.
   assign ctrl_d = '{
      wb_en:    wb_en_in    & valid_in,
      mem_r_en: mem_r_en_in & valid_in,
      mem_w_en: mem_w_en_in & valid_in,
      b:        b_in        & valid_in,
      s:        s_in        & valid_in
   };

   assign bubble = flush | (~freeze & ~valid_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out         <= 1'b0;
         ctrl_q            <= '0;
         exe_cmd_out       <= '0;
         pc_out            <= '0;
         val_rn_out        <= '0;
         val_rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         signed_imm_24_out <= '0;
         dest_out          <= '0;
         src1_out          <= '0;
         src2_out          <= '0;
         status_out        <= '0;
      end else if (flush) begin
         valid_out <= 1'b0;
         ctrl_q    <= '0;
      end else if (!freeze) begin
         valid_out         <= valid_in;
         ctrl_q            <= ctrl_d;
         exe_cmd_out       <= exe_cmd_in;
         pc_out            <= pc_in;
         val_rn_out        <= val_rn_in;
         val_rm_out        <= val_rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         signed_imm_24_out <= signed_imm_24_in;
         dest_out          <= dest_in;
         src1_out          <= src1_in;
         src2_out          <= src2_in;
         status_out        <= status_in;
      end
   end

   assign wb_en_out    = ctrl_q.wb_en;
   assign mem_r_en_out = ctrl_q.mem_r_en;
   assign mem_w_en_out = ctrl_q.mem_w_en;
   assign b_out        = ctrl_q.b;
   assign s_out        = ctrl_q.s;

   sat_counter #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .en    (bubble),
      .cnt   (bubble_cnt)
   );

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg (CNT_W=4 build to reach saturation).
// Driver pushes expected outputs; a negedge monitor pops and compares.
module tb_id_exe_reg;
   import id_exe_reg_pkg::*;

   typedef struct packed {
      logic        valid;
      logic        wb;
      logic        mr;
      logic        mw;
      logic        b;
      logic        s;
      logic [3:0]  cmd;
      logic [31:0] pc;
      logic [31:0] rn;
      logic [31:0] rm;
      logic        imm;
      logic [11:0] sh;
      logic [23:0] off;
      logic [3:0]  dest;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  st;
   } in_t;

   typedef struct packed {
      in_t        f;
      logic [3:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic freeze = 1'b0;
   logic flush = 1'b0;
   in_t  ins = '0;

   logic        valid_out, wb_en_out, mem_r_en_out;
   logic        mem_w_en_out, b_out, s_out, imm_out;
   logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
   logic [3:0]  status_out, bubble_cnt;
   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [11:0] shift_operand_out;
   logic [23:0] signed_imm_24_out;

   obs_t m = '0;
   obs_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   id_exe_reg #(
      .CNT_W (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .freeze            (freeze),
      .flush             (flush),
      .valid_in          (ins.valid),
      .wb_en_in          (ins.wb),
      .mem_r_en_in       (ins.mr),
      .mem_w_en_in       (ins.mw),
      .b_in              (ins.b),
      .s_in              (ins.s),
      .exe_cmd_in        (ins.cmd),
      .pc_in             (ins.pc),
      .val_rn_in         (ins.rn),
      .val_rm_in         (ins.rm),
      .imm_in            (ins.imm),
      .shift_operand_in  (ins.sh),
      .signed_imm_24_in  (ins.off),
      .dest_in           (ins.dest),
      .src1_in           (ins.s1),
      .src2_in           (ins.s2),
      .status_in         (ins.st),
      .valid_out         (valid_out),
      .wb_en_out         (wb_en_out),
      .mem_r_en_out      (mem_r_en_out),
      .mem_w_en_out      (mem_w_en_out),
      .b_out             (b_out),
      .s_out             (s_out),
      .exe_cmd_out       (exe_cmd_out),
      .pc_out            (pc_out),
      .val_rn_out        (val_rn_out),
      .val_rm_out        (val_rm_out),
      .imm_out           (imm_out),
      .shift_operand_out (shift_operand_out),
      .signed_imm_24_out (signed_imm_24_out),
      .dest_out          (dest_out),
      .src1_out          (src1_out),
      .src2_out          (src2_out),
      .status_out        (status_out),
      .bubble_cnt        (bubble_cnt)
   );

   // Monitor: one expected entry per negedge, if any is pending.
   always @(negedge clk) begin
      obs_t a;
      obs_t e;
      if (q.size() != 0) begin
         e = q.pop_front();
         a.f = {valid_out, wb_en_out, mem_r_en_out, mem_w_en_out,
                b_out, s_out, exe_cmd_out, pc_out, val_rn_out,
                val_rm_out, imm_out, shift_operand_out,
                signed_imm_24_out, dest_out, src1_out, src2_out,
                status_out};
         a.cnt = bubble_cnt;
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL chk%0d t=%0t got %h want %h",
                     n_chk, $time, a, e);
         end
         if (mem_r_en_out && !valid_out) begin
            n_fail++;
            $display("FAIL load_use_dead chk%0d mem_r_en=1 want 0",
                     n_chk);
         end
      end
   end

   // Expected next state per clock edge, written from the block's rules.
   task automatic step(input logic fl, input logic fz);
      flush  = fl;
      freeze = fz;
      @(posedge clk);
      if (fl) begin
         m.f.valid = 1'b0;
         {m.f.wb, m.f.mr, m.f.mw, m.f.b, m.f.s} = '0;
         if (m.cnt != 4'hf) m.cnt = m.cnt + 4'd1;
      end else if (!fz) begin
         m.f = ins;
         m.f.wb = ins.wb & ins.valid;
         m.f.mr = ins.mr & ins.valid;
         m.f.mw = ins.mw & ins.valid;
         m.f.b  = ins.b & ins.valid;
         m.f.s  = ins.s & ins.valid;
         if (!ins.valid && m.cnt != 4'hf) m.cnt = m.cnt + 4'd1;
      end
      #1;
      q.push_back(m);
   endtask

   // Asserts reset between edges, then releases after the next edge.
   task automatic do_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 m = '0;
      q.push_back(m);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      #1 rst_n = 1'b0;
      q.push_back(m);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // two dead slots bump the counter, then a valid ADD to R3
      step(0, 0);
      step(0, 0);
      ins.valid = 1; ins.wb = 1; ins.cmd = CMD_ADD; ins.dest = 3;
      ins.s1 = 1; ins.s2 = 2; ins.rn = 32'h11; ins.rm = 32'h22;
      ins.pc = 32'h104;
      step(0, 0);
      do_reset();

      // normal load, then freeze with changed inputs
      ins = '0;
      ins.valid = 1; ins.wb = 1; ins.dest = 5; ins.s1 = 2;
      ins.rn = 32'h1234; ins.pc = 32'h200; ins.st = 4'h9;
      step(0, 0);
      ins.dest = 9; ins.rn = 32'hdead_beef; ins.valid = 0;
      ins.mr = 1; ins.pc = 32'h300;
      repeat (3) step(0, 1);
      step(1, 1);

      // dead slot with control asserted
      ins = '0;
      ins.wb = 1; ins.mr = 1; ins.dest = 7;
      step(0, 0);

      // every field driven, then freeze, then flush alone
      ins = '{valid: 1, wb: 1, mr: 1, mw: 1, b: 1, s: 1,
              cmd: CMD_LDR, pc: 32'h0000_1004,
              rn: 32'hcafe_f00d, rm: 32'h8000_0001, imm: 1,
              sh: 12'habc, off: 24'h80_0001, dest: 4'hf,
              s1: 4'he, s2: 4'hd, st: 4'hf};
      step(0, 0);
      ins.valid = 0; ins.pc = 32'h5;
      step(0, 1);
      step(1, 0);
      step(0, 1);

      // saturation: 17 flushes, then more bubble sources
      do_reset();
      ins = '0;
      ins.valid = 1; ins.mr = 1; ins.dest = 2;
      repeat (17) step(1, 0);
      step(0, 0);
      ins.valid = 0;
      step(0, 0);
      step(1, 0);

      repeat (2) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain %0d entries left want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the ID stage and the EXE stage of the 5-stage core.
- Captures decoded control, operand values and the source/destination register IDs. EXE and the forwarding unit use src1/src2 to build sel_src1/sel_src2.
- Implements the stall (freeze) and branch-flush (bubble) rules for this boundary.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of PC, register values and sign-extended fields
- REG_ID_W, 4, register-ID width (16 architectural registers)
- CMD_W, 4, ALU command width
- CNT_W, 16, bubble-counter width

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- freeze  in  1  hold every stored field (hazard stall)
- flush  in  1  insert bubble (branch taken in EXE)
- valid_in  in  1  ID holds a real instruction
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  decoded control bits
- exe_cmd_in  in  CMD_W  ALU command
- pc_in, val_rn_in, val_rm_in  in  DATA_W  PC+4 and register-file reads
- imm_in  in  1  operand-2 immediate select
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in, src1_in, src2_in  in  REG_ID_W  register IDs
- status_in  in  4  NZCV flags
- All of the above have matching registered outputs with suffix _out, same widths
- valid_out  out  1  stage holds a real instruction
- bubble_cnt  out  CNT_W  bubbles inserted since reset

Behaviour:
- Latency: one cycle. Fields sampled on the rising clk edge and driven from flops; no combinational path from input to output.
- Reset (rst_n=0, asynchronous, takes effect immediately): every output is 0, including valid_out, all control bits, IDs, values and bubble_cnt. Reset wins over any other input. Release is synchronous to the next edge in the implementation's reset synchroniser domain. The block itself only samples rst_n asynchronously.
- Per-edge priority: flush > freeze > load.
  - flush=1: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out and s_out go to 0. All data, ID, cmd and status fields hold their previous value. flush overrides freeze in the same cycle.
  - flush=0, freeze=1: every output holds, including valid_out and bubble_cnt.
  - flush=0, freeze=0: all fields load from inputs. The control bits load as (ctrl_in & valid_in), so valid_in=0 always presents an all-zero control set. This guarantees the forwarding unit never matches on a dead slot.
- Bubble counter:
  - Increments by 1 on an edge where flush=1, or where a load occurs with valid_in=0.
  - Saturates at all-ones; never wraps.
  - Does not increment while frozen.
- mem_r_en_out is the load-use indicator consumed by the hazard unit. It must be 0 whenever valid_out=0.
- Sustained freeze, with any value on the data inputs, leaves outputs bit-identical.

Decomposition:
- Shared package holds:
  - REG_ID_W, DATA_W, CMD_W constants.
  - An exe_cmd encoding enum (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR).
  - A ctrl_t struct {wb_en, mem_r_en, mem_w_en, b, s}.
- One sub-module: sat_counter (width-parameterised, enable, asynchronous active-low clear), used for bubble_cnt.
- Everything else is flat flops in id_exe_reg.

Test Plan:
- Reset mid-run: load valid ADD to R3, assert rst_n=0 between edges -> all outputs 0 immediately, bubble_cnt=0.
- Normal load: valid_in=1, wb_en_in=1, dest_in=5, src1_in=2, val_rn_in=0x1234 -> next edge wb_en_out=1, dest_out=5, src1_out=2, val_rn_out=0x1234, valid_out=1.
- Freeze: after the load above, freeze=1 for 3 cycles with changed inputs (dest_in=9) -> dest_out stays 5, valid_out=1, bubble_cnt unchanged.
- Flush+freeze together: flush=1, freeze=1 -> valid_out=0, wb_en_out=0, mem_r_en_out=0, dest_out still 5, bubble_cnt +1.
- Invalid slot: valid_in=0 with wb_en_in=1, mem_r_en_in=1 -> wb_en_out=0, mem_r_en_out=0, bubble_cnt +1.
- Saturation (CNT_W=4 build): 17 consecutive flushes -> bubble_cnt=0xF, holds at 0xF.
